// File: rtl/seq_divider_16_bit.sv
// 16-bit unsigned restoring divider: one quotient bit per clock by shift-and-trial-subtract,
// driven by a start/done handshake. A zero divisor short-circuits straight to DONE.
module seq_divider_16_bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, next_state;
  logic [15:0] q_reg;
  logic [15:0] d_reg;
  logic [16:0] r_reg;
  logic [3:0]  count;

  logic [17:0] trial;
  logic        borrow;
  logic [16:0] next_r;
  logic [15:0] next_q;
  logic        accept;
  logic        zero_div;

  assign accept   = (state == IDLE) && start;
  assign zero_div = (divisor == 16'd0);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // One iteration: {R,Q} << 1, then trial-subtract D from the shifted remainder.
  // The subtract is one bit wider than R so the borrow lands in trial[17].
  always_comb begin
    trial  = {r_reg, q_reg[15]} - {2'b00, d_reg};
    borrow = trial[17];
    next_r = borrow ? {r_reg[15:0], q_reg[15]} : trial[16:0];
    next_q = {q_reg[14:0], ~borrow};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = zero_div ? DONE : RUN;
      RUN:     if (count == 4'd15) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        if (zero_div) begin
          quotient    <= 16'hFFFF;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          q_reg <= dividend;
          d_reg <= divisor;
          r_reg <= '0;
          count <= '0;
        end
      end else if (state == RUN) begin
        q_reg <= next_q;
        r_reg <= next_r;
        count <= count + 4'd1;
        // Results are published only on the final iteration, never as partials.
        if (count == 4'd15) begin
          quotient    <= next_q;
          remainder   <= next_r[15:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_16_bit.sv
// Directed bench for seq_divider_16_bit: expected results are queued at launch
// and popped when done is seen; handshake timing is checked alongside.
module tb_seq_divider_16_bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  seq_divider_16_bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected result, then drive a one-cycle start accepted at the next edge (E0).
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) e = '{q: 16'hFFFF, r: a, dz: 1'b1};
    else            e = '{q: a / b, r: a % b, dz: 1'b0};
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
  endtask

  // Wait for done (bounded), checking the edge it appears on, busy length and results.
  task automatic collect(input string tag, input int exp_edge, input int exp_busy);
    int   done_edge = 0;
    int   busy_cnt  = 0;
    bit   seen      = 1'b0;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check({tag, "_busy_done_excl"}, {31'b0, busy & done}, 32'd0);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk);
      done_edge++;
    end
    if (!seen) begin
      check({tag, "_timeout"}, {31'b0, seen}, 32'd1);
      return;
    end
    check({tag, "_latency"}, done_edge, exp_edge);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, sb.size(), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_quotient"}, quotient, e.q);
    check({tag, "_remainder"}, remainder, e.r);
    check({tag, "_div_by_zero"}, div_by_zero, e.dz);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_held_q"}, quotient, e.q);
    check({tag, "_held_r"}, remainder, e.r);
  endtask

  initial begin
    bit extra_done;
    logic [15:0] ra, rb;

    // Reset state
    #3;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    launch(16'd100, 16'd7);         collect("d100_7", 16, 16);
    launch(16'hFFFF, 16'd1);        collect("dffff_1", 16, 16);
    launch(16'hFFFF, 16'h8001);     collect("dffff_8001", 16, 16);
    launch(16'd3, 16'd10);          collect("d3_10", 16, 16);
    launch(16'd5, 16'd0);           collect("d5_0", 0, 0);
    // Issued two cycles after the divide-by-zero start: must be accepted.
    launch(16'd7, 16'd2);           collect("d7_2_after_dz", 16, 16);
    launch(16'd0, 16'd0);           collect("d0_0", 0, 0);
    launch(16'd0, 16'hFFFF);        collect("d0_ffff", 16, 16);

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(1, 65535));
      launch(ra, rb);
      collect("rand", 16, 16);
    end

    // Start pulse at cycle 5 of a run must be ignored.
    launch(16'd1000, 16'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 16'd9; divisor = 16'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    collect("d1000_3_ign", 11, 11);
    extra_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) extra_done = 1'b1;
    end
    check("ignored_start_no_extra_done", {31'b0, extra_done}, 32'd0);

    // Asynchronous reset mid-division at cycle 8.
    launch(16'd1000, 16'd3);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_quotient", quotient, 32'd0);
    check("arst_remainder", remainder, 32'd0);
    check("arst_dz", {31'b0, div_by_zero}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    launch(16'd9, 16'd9);           collect("d9_9_after_rst", 16, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
